// File: rtl/autenticacao_pkg.sv
// Shared types and constants for the sequential code-authentication block.
// Holds the FSM state encoding, the status display segment patterns and
// the state-to-pattern mapping used by the top-level output register.
package autenticacao_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      CHECK   = 3'd2,
      GRANT   = 3'd3,
      DENY    = 3'd4,
      LOCKOUT = 3'd5
   } state_t;

   // Segment patterns, bit 6 = segment a down to bit 0 = segment g
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_H    = 7'b0110111;
   localparam logic [6:0] SEG_A    = 7'b1110111;
   localparam logic [6:0] SEG_E    = 7'b1001111;
   localparam logic [6:0] SEG_L    = 7'b0001110;

   // Display pattern shown while the FSM sits in a given state
   function automatic logic [6:0] seg_for_state(input state_t s);
      logic [6:0] seg;
      case (s)
         IDLE:    seg = SEG_DASH;
         ENTRY:   seg = SEG_H;
         CHECK:   seg = SEG_H;
         GRANT:   seg = SEG_A;
         DENY:    seg = SEG_E;
         LOCKOUT: seg = SEG_L;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/autenticacao_timer.sv
// Loadable down-counter with a done flag. The authentication FSM loads it
// when entering GRANT, DENY or LOCKOUT and leaves the state once done is
// seen, so a load of N-1 keeps the state for exactly N cycles.
module autenticacao_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Load has priority; otherwise count down and park at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/autenticacao_sequencial.sv
// Clocked code-authentication block. Digits arrive one per digit_valid
// strobe and are compared against the stored CODE. The full code length is
// always collected before judging, so a wrong digit never shortens entry.
// Failed attempts are counted and MAX_TRIES failures cause a timed lockout.
// All outputs are registered from the next state so they line up with it.
module autenticacao_sequencial
   import autenticacao_pkg::*;
#(
   parameter int                         DIGIT_W     = 3,
   parameter int                         CODE_LEN    = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0] CODE       = 12'h3D5,
   parameter int                         MAX_TRIES   = 3,
   parameter int                         HOLD_CYCLES = 4,
   parameter int                         LOCK_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DIGIT_W-1:0]             digit_in,
   input  logic                           digit_valid,
   input  logic                           clear,
   output logic                           granted,
   output logic                           denied,
   output logic                           locked,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
   output logic [6:0]                     P
);

   localparam int TRIES_W   = $clog2(MAX_TRIES + 1);
   localparam int IDX_W     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int TIMER_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
   localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_LEN - 1);
   localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
   localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);

   state_t               state, state_next;
   logic [IDX_W-1:0]     idx, idx_next;
   logic                 mismatch, mismatch_next;
   logic [TRIES_W-1:0]   tries_next;
   logic [DIGIT_W-1:0]   digit_ref;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_value;
   logic                 timer_done;

   autenticacao_timer #(
      .WIDTH(TIMER_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   // State, entry bookkeeping and the registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         mismatch   <= 1'b0;
         tries_left <= TRIES_MAX;
         granted    <= 1'b0;
         denied     <= 1'b0;
         locked     <= 1'b0;
         P          <= SEG_DASH;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         mismatch   <= mismatch_next;
         tries_left <= tries_next;
         granted    <= (state_next == GRANT);
         denied     <= (state_next == DENY);
         locked     <= (state_next == LOCKOUT);
         P          <= seg_for_state(state_next);
      end
   end

   // Next-state logic; strobes outside IDLE/ENTRY are simply dropped
   always_comb begin
      state_next    = state;
      idx_next      = idx;
      mismatch_next = mismatch;
      tries_next    = tries_left;
      timer_load    = 1'b0;
      timer_value   = HOLD_LOAD;
      digit_ref     = CODE[DIGIT_W*int'(idx) +: DIGIT_W];

      case (state)
         IDLE: begin
            if (clear) begin
               idx_next      = '0;
               mismatch_next = 1'b0;
            end else if (digit_valid) begin
               mismatch_next = (digit_in != digit_ref);
               if (CODE_LEN == 1) begin
                  idx_next   = '0;
                  state_next = CHECK;
               end else begin
                  idx_next   = IDX_W'(1);
                  state_next = ENTRY;
               end
            end
         end
         ENTRY: begin
            if (clear) begin
               idx_next      = '0;
               mismatch_next = 1'b0;
               state_next    = IDLE;
            end else if (digit_valid) begin
               mismatch_next = mismatch | (digit_in != digit_ref);
               if (idx == LAST_IDX) begin
                  idx_next   = '0;
                  state_next = CHECK;
               end else begin
                  idx_next   = idx + 1'b1;
               end
            end
         end
         CHECK: begin
            timer_load  = 1'b1;
            timer_value = HOLD_LOAD;
            if (mismatch) begin
               state_next = DENY;
               tries_next = tries_left - 1'b1;
            end else begin
               state_next = GRANT;
               tries_next = TRIES_MAX;
            end
         end
         GRANT: begin
            if (timer_done) begin
               idx_next      = '0;
               mismatch_next = 1'b0;
               state_next    = IDLE;
            end
         end
         DENY: begin
            if (timer_done) begin
               idx_next      = '0;
               mismatch_next = 1'b0;
               if (tries_left == '0) begin
                  timer_load  = 1'b1;
                  timer_value = LOCK_LOAD;
                  state_next  = LOCKOUT;
               end else begin
                  state_next  = IDLE;
               end
            end
         end
         LOCKOUT: begin
            if (timer_done) begin
               tries_next = TRIES_MAX;
               state_next = IDLE;
            end
         end
         default: begin
            idx_next      = '0;
            mismatch_next = 1'b0;
            state_next    = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_autenticacao_sequencial.sv
// Directed self-checking bench for autenticacao_sequencial with default
// parameters (code 5,2,7,1, three tries, hold 4, lockout 16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_autenticacao_sequencial;

   logic       clk;
   logic       rst;
   logic [2:0] digit_in;
   logic       digit_valid;
   logic       clear;
   logic       granted;
   logic       denied;
   logic       locked;
   logic [1:0] tries_left;
   logic [6:0] P;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] PAT_DASH = 7'b0000001;
   localparam logic [6:0] PAT_H    = 7'b0110111;
   localparam logic [6:0] PAT_A    = 7'b1110111;
   localparam logic [6:0] PAT_E    = 7'b1001111;
   localparam logic [6:0] PAT_L    = 7'b0001110;

   autenticacao_sequencial dut (
      .clk         (clk),
      .rst         (rst),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .clear       (clear),
      .granted     (granted),
      .denied      (denied),
      .locked      (locked),
      .tries_left  (tries_left),
      .P           (P)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs and advance to the next falling edge
   task automatic applyStimulus(input logic [2:0] d, input logic v, input logic c);
      digit_in    = d;
      digit_valid = v;
      clear       = c;
      @(negedge clk);
   endtask

   // Four back-to-back strobes; afterwards the DUT should be in CHECK
   task automatic enterCode(input logic [2:0] d0, input logic [2:0] d1,
                            input logic [2:0] d2, input logic [2:0] d3);
      applyStimulus(d0, 1'b1, 1'b0);
      applyStimulus(d1, 1'b1, 1'b0);
      applyStimulus(d2, 1'b1, 1'b0);
      applyStimulus(d3, 1'b1, 1'b0);
   endtask

   // One wrong code that does not lock: CHECK, four deny cycles, back to IDLE
   task automatic wrongCodeNoLock(input logic [1:0] tries_after);
      enterCode(3'd0, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'd0, 1'b0, 1'b0);
         checkOutput("deny_hold", {31'd0, denied}, 32'd1);
      end
      checkOutput("deny_tries", {30'd0, tries_left}, {30'd0, tries_after});
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("deny_exit_P", {25'd0, P}, {25'd0, PAT_DASH});
   endtask

   // Correct code followed by the full grant hold and the return to IDLE
   task automatic goodCodeGrant(input string tag);
      enterCode(3'd5, 3'd2, 3'd7, 3'd1);
      checkOutput({tag, "_check_granted"}, {31'd0, granted}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'd0, 1'b0, 1'b0);
         checkOutput({tag, "_granted"}, {31'd0, granted}, 32'd1);
      end
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput({tag, "_idle_granted"}, {31'd0, granted}, 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      digit_in    = 3'd0;
      digit_valid = 1'b0;
      clear       = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      checkOutput("rst_granted", {31'd0, granted}, 32'd0);
      checkOutput("rst_denied",  {31'd0, denied},  32'd0);
      checkOutput("rst_locked",  {31'd0, locked},  32'd0);
      checkOutput("rst_tries",   {30'd0, tries_left}, 32'd3);
      checkOutput("rst_P",       {25'd0, P}, {25'd0, PAT_DASH});
      rst = 1'b0;
      @(negedge clk);

      // Correct code: CHECK one cycle, then four GRANT cycles, then IDLE
      enterCode(3'd5, 3'd2, 3'd7, 3'd1);
      checkOutput("t1_check_P", {25'd0, P}, {25'd0, PAT_H});
      checkOutput("t1_check_granted", {31'd0, granted}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'd0, 1'b0, 1'b0);
         checkOutput("t1_granted", {31'd0, granted}, 32'd1);
         checkOutput("t1_grant_P", {25'd0, P}, {25'd0, PAT_A});
         checkOutput("t1_tries", {30'd0, tries_left}, 32'd3);
      end
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("t1_idle_granted", {31'd0, granted}, 32'd0);
      checkOutput("t1_idle_P", {25'd0, P}, {25'd0, PAT_DASH});

      // Last digit wrong: four DENY cycles, one try consumed
      enterCode(3'd5, 3'd2, 3'd7, 3'd0);
      checkOutput("t2_check_P", {25'd0, P}, {25'd0, PAT_H});
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'd0, 1'b0, 1'b0);
         checkOutput("t2_denied", {31'd0, denied}, 32'd1);
         checkOutput("t2_deny_P", {25'd0, P}, {25'd0, PAT_E});
         checkOutput("t2_tries", {30'd0, tries_left}, 32'd2);
      end
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("t2_idle_denied", {31'd0, denied}, 32'd0);
      checkOutput("t2_idle_locked", {31'd0, locked}, 32'd0);
      checkOutput("t2_idle_P", {25'd0, P}, {25'd0, PAT_DASH});

      // A correct code restores the try counter
      goodCodeGrant("t2b");
      checkOutput("t2b_tries", {30'd0, tries_left}, 32'd3);

      // Three wrong codes lead to lockout; strobes during lockout are dropped
      wrongCodeNoLock(2'd2);
      wrongCodeNoLock(2'd1);
      enterCode(3'd0, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'd0, 1'b0, 1'b0);
         checkOutput("t3_denied", {31'd0, denied}, 32'd1);
      end
      checkOutput("t3_tries_zero", {30'd0, tries_left}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         case (i)
            0:       applyStimulus(3'd5, 1'b1, 1'b0);
            1:       applyStimulus(3'd2, 1'b1, 1'b0);
            2:       applyStimulus(3'd7, 1'b1, 1'b0);
            3:       applyStimulus(3'd1, 1'b1, 1'b0);
            default: applyStimulus(3'd0, 1'b0, 1'b0);
         endcase
         checkOutput("t3_locked", {31'd0, locked}, 32'd1);
         checkOutput("t3_lock_P", {25'd0, P}, {25'd0, PAT_L});
         checkOutput("t3_lock_granted", {31'd0, granted}, 32'd0);
      end
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("t3_unlocked", {31'd0, locked}, 32'd0);
      checkOutput("t3_tries_restored", {30'd0, tries_left}, 32'd3);
      checkOutput("t3_unlock_P", {25'd0, P}, {25'd0, PAT_DASH});
      goodCodeGrant("t3_after");

      // Clear together with a strobe aborts entry without using a try
      applyStimulus(3'd5, 1'b1, 1'b0);
      applyStimulus(3'd2, 1'b1, 1'b0);
      checkOutput("t4_entry_P", {25'd0, P}, {25'd0, PAT_H});
      applyStimulus(3'd7, 1'b1, 1'b1);
      checkOutput("t4_clear_P", {25'd0, P}, {25'd0, PAT_DASH});
      checkOutput("t4_clear_tries", {30'd0, tries_left}, 32'd3);
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("t4_still_idle", {25'd0, P}, {25'd0, PAT_DASH});
      goodCodeGrant("t4_after");

      // Asynchronous reset in the middle of a lockout
      wrongCodeNoLock(2'd2);
      wrongCodeNoLock(2'd1);
      enterCode(3'd0, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 8; i++) applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("t5_pre_locked", {31'd0, locked}, 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5_rst_locked", {31'd0, locked}, 32'd0);
      checkOutput("t5_rst_tries", {30'd0, tries_left}, 32'd3);
      checkOutput("t5_rst_P", {25'd0, P}, {25'd0, PAT_DASH});
      #1 rst = 1'b0;
      @(negedge clk);
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("t5_after_locked", {31'd0, locked}, 32'd0);

      // Strobe held high through CHECK and GRANT: no second evaluation
      enterCode(3'd5, 3'd2, 3'd7, 3'd1);
      checkOutput("t6_check_P", {25'd0, P}, {25'd0, PAT_H});
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'd5, 1'b1, 1'b0);
         checkOutput("t6_granted", {31'd0, granted}, 32'd1);
      end
      applyStimulus(3'd5, 1'b1, 1'b0);
      checkOutput("t6_idle_P", {25'd0, P}, {25'd0, PAT_DASH});
      checkOutput("t6_idle_granted", {31'd0, granted}, 32'd0);
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput("t6_no_reentry_P", {25'd0, P}, {25'd0, PAT_DASH});
      checkOutput("t6_tries", {30'd0, tries_left}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
